stdp_synapse: RTL and testbench

Plastic synapse between a presynaptic spike source and the postsynaptic LIF neuron. It consumes both spike trains and tracks the time since each side last spiked. It applies a pair-based STDP rule to an 8-bit weight and drives the weighted synaptic current into the postsynaptic neuron's `current` input. It is the receiving end of the LIF spike interface: spikes in, learned weight and current out.

---
 rtl/stdp_pkg.sv | 41 ++++
 rtl/stdp_age_counter.sv | 35 +++
 rtl/stdp_synapse.sv | 111 +++++++++++
 tb/tb_stdp_synapse.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types, default constants and saturating weight arithmetic for the STDP synapse.
// The 9-bit intermediate keeps the carry/borrow visible before clamping.
package stdp_pkg;

  localparam int          DEF_AGE_W  = 4;
  localparam logic [7:0]  DEF_W_INIT = 8'd64;
  localparam logic [7:0]  DEF_W_MAX  = 8'd255;
  localparam logic [7:0]  DEF_W_MIN  = 8'd0;
  localparam logic [7:0]  DEF_DW_MAX = 8'd16;
  localparam int          DEF_WIN    = 4;

  typedef logic [7:0]           weight_t;
  typedef logic [DEF_AGE_W-1:0] age_t;

  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_LTP  = 2'd1,
    UPD_LTD  = 2'd2
  } upd_kind_e;

  function automatic weight_t sat_add(input weight_t w, input weight_t d, input weight_t w_max);
    logic [8:0] sum;
    sum = {1'b0, w} + {1'b0, d};
    if (sum > {1'b0, w_max}) begin
      return w_max;
    end else begin
      return sum[7:0];
    end
  endfunction

  function automatic weight_t sat_sub(input weight_t w, input weight_t d, input weight_t w_min);
    logic [8:0] diff;
    diff = {1'b0, w} - {1'b0, d};
    if (diff[8] || (diff[7:0] < w_min)) begin
      return w_min;
    end else begin
      return diff[7:0];
    end
  endfunction

endpackage

// File: rtl/stdp_age_counter.sv
// Cycles-since-last-spike counter: 0 = never spiked, loads 1 on a spike,
// then counts up and sticks at all-ones so a stale spike never re-enters the window.
module stdp_age_counter
  import stdp_pkg::*;
#(
  parameter int AGE_W = DEF_AGE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_spike,
  output logic [AGE_W-1:0] o_age
);

  localparam logic [AGE_W-1:0] AGE_ZERO = '0;
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_SAT  = '1;

  logic [AGE_W-1:0] r_age;

  // Age register: reload on spike, otherwise saturating increment once armed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_age <= AGE_ZERO;
    end else if (i_spike) begin
      r_age <= AGE_ONE;
    end else if ((r_age != AGE_ZERO) && (r_age != AGE_SAT)) begin
      r_age <= r_age + AGE_ONE;
    end else begin
      r_age <= r_age;
    end
  end

  assign o_age = r_age;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: nearest-neighbour pairing of pre/post spikes adjusts an
// 8-bit saturating weight; the pre-update weight is forwarded as synaptic current.
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter logic [7:0] W_INIT = DEF_W_INIT,
  parameter logic [7:0] W_MAX  = DEF_W_MAX,
  parameter logic [7:0] W_MIN  = DEF_W_MIN,
  parameter logic [7:0] DW_MAX = DEF_DW_MAX,
  parameter int         WIN    = DEF_WIN,
  parameter int         AGE_W  = DEF_AGE_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  output logic [7:0] weight,
  output logic [7:0] syn_current,
  output logic       update_w_flag,
  output logic       ltp
);

  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] WIN_A   = AGE_W'(WIN);

  logic [AGE_W-1:0] w_pre_age;
  logic [AGE_W-1:0] w_post_age;
  logic [7:0]       w_delta_pre;
  logic [7:0]       w_delta_post;
  upd_kind_e        w_kind;
  weight_t          w_next_weight;
  logic             w_changed;

  weight_t          r_weight;
  logic [7:0]       r_syn_current;
  logic             r_update_w_flag;
  logic             r_ltp;

  stdp_age_counter #(.AGE_W(AGE_W)) u_pre_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_spike (pre_spike),
    .o_age   (w_pre_age)
  );

  stdp_age_counter #(.AGE_W(AGE_W)) u_post_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_spike (post_spike),
    .o_age   (w_post_age)
  );

  // Delta shifter: step halves per cycle of separation, zero outside 1..WIN.
  always_comb begin
    w_delta_pre  = 8'd0;
    w_delta_post = 8'd0;
    if ((w_pre_age >= AGE_ONE) && (w_pre_age <= WIN_A)) begin
      w_delta_pre = DW_MAX >> (w_pre_age - AGE_ONE);
    end else begin
      w_delta_pre = 8'd0;
    end
    if ((w_post_age >= AGE_ONE) && (w_post_age <= WIN_A)) begin
      w_delta_post = DW_MAX >> (w_post_age - AGE_ONE);
    end else begin
      w_delta_post = 8'd0;
    end
  end

  // LTP/LTD decision; coincident spikes and out-of-window ages leave the weight alone.
  always_comb begin
    w_kind        = UPD_NONE;
    w_next_weight = r_weight;
    if (learn_en && post_spike && !pre_spike && (w_delta_pre != 8'd0)) begin
      w_kind        = UPD_LTP;
      w_next_weight = sat_add(r_weight, w_delta_pre, W_MAX);
    end else if (learn_en && pre_spike && !post_spike && (w_delta_post != 8'd0)) begin
      w_kind        = UPD_LTD;
      w_next_weight = sat_sub(r_weight, w_delta_post, W_MIN);
    end else begin
      w_kind        = UPD_NONE;
      w_next_weight = r_weight;
    end
    w_changed = (w_next_weight != r_weight);
  end

  // Weight and output registers; ltp only moves when the weight actually moved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_weight        <= W_INIT;
      r_syn_current   <= 8'd0;
      r_update_w_flag <= 1'b0;
      r_ltp           <= 1'b0;
    end else begin
      r_weight        <= w_next_weight;
      r_syn_current   <= pre_spike ? r_weight : 8'd0;
      r_update_w_flag <= w_changed;
      if (w_changed) begin
        r_ltp <= (w_kind == UPD_LTP);
      end else begin
        r_ltp <= r_ltp;
      end
    end
  end

  assign weight        = r_weight;
  assign syn_current   = r_syn_current;
  assign update_w_flag = r_update_w_flag;
  assign ltp           = r_ltp;

endmodule

// File: tb/tb_stdp_synapse.sv
// Self-checking bench: directed pairing scenarios then random spike trains, compared
// each cycle against a spike-timestamp model of the STDP rule.
module tb_stdp_synapse;

  logic       clk;
  logic       rst_n;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic [7:0] weight;
  logic [7:0] syn_current;
  logic       update_w_flag;
  logic       ltp;

  int checks;
  int errors;

  // Reference model state: absolute cycle numbers of the last spikes (-1 = none).
  int cyc;
  int last_pre;
  int last_post;
  int m_w;
  int m_syn;
  int m_flag;
  int m_ltp;

  stdp_synapse dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pre_spike     (pre_spike),
    .post_spike    (post_spike),
    .learn_en      (learn_en),
    .weight        (weight),
    .syn_current   (syn_current),
    .update_w_flag (update_w_flag),
    .ltp           (ltp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int delta_of(input int dt);
    if (dt >= 1 && dt <= 4) return 16 >> (dt - 1);
    return 0;
  endfunction

  task automatic model_edge(input bit pre, input bit post, input bit learn, input bit rstn);
    int nw;
    int d;
    if (!rstn) begin
      last_pre  = -1;
      last_post = -1;
      m_w = 64; m_syn = 0; m_flag = 0; m_ltp = 0;
    end else begin
      m_syn = pre ? m_w : 0;
      nw = m_w;
      if (learn && post && !pre && last_pre >= 0) begin
        d = delta_of(cyc - last_pre);
        if (d > 0) nw = (m_w + d > 255) ? 255 : m_w + d;
      end else if (learn && pre && !post && last_post >= 0) begin
        d = delta_of(cyc - last_post);
        if (d > 0) nw = (m_w - d < 0) ? 0 : m_w - d;
      end
      m_flag = (nw != m_w) ? 1 : 0;
      if (m_flag == 1) m_ltp = post ? 1 : 0;
      m_w = nw;
      if (pre)  last_pre  = cyc;
      if (post) last_post = cyc;
    end
  endtask

  task automatic step(input bit pre, input bit post, input bit learn, input bit rstn);
    @(negedge clk);
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    rst_n      = rstn;
    model_edge(pre, post, learn, rstn);
    @(posedge clk);
    #1;
    check_val("weight", int'(weight), m_w);
    check_val("syn_current", int'(syn_current), m_syn);
    check_val("update_w_flag", int'(update_w_flag), m_flag);
    check_val("ltp", int'(ltp), m_ltp);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Pre spike followed by post spike dt cycles later, then quiet until ages go stale.
  task automatic pair_ltp(input int dt);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    if (dt > 1) idle(dt - 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(6);
  endtask

  task automatic pair_ltd(input int dt);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    if (dt > 1) idle(dt - 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(6);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    last_pre = -1; last_post = -1;
    m_w = 64; m_syn = 0; m_flag = 0; m_ltp = 0;
    pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1; rst_n = 1'b0;

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("reset_weight", int'(weight), 64);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("post_no_pre", int'(weight), 64);
    idle(6);

    // dt=1 potentiation, then dt=4 and dt=5.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("ltp_dt1_weight", int'(weight), 80);
    check_val("ltp_dt1_flag", int'(update_w_flag), 1);
    check_val("ltp_dt1_dir", int'(ltp), 1);
    idle(6);
    pair_ltp(4);
    check_val("ltp_dt4_weight", int'(weight), 82);
    pair_ltp(5);
    check_val("ltp_dt5_weight", int'(weight), 82);

    // Back to 64 via reset, then dt=2 depression and syn_current.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_val("ltd_dt2_weight", int'(weight), 56);
    check_val("ltd_dt2_dir", int'(ltp), 0);
    check_val("ltd_syn_current", int'(syn_current), 64);
    idle(6);

    // Upper saturation: reach 250 then push past W_MAX twice.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) pair_ltp(1);
    pair_ltp(2);
    pair_ltp(4);
    check_val("reach_250", int'(weight), 250);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("sat_max_weight", int'(weight), 255);
    check_val("sat_max_flag", int'(update_w_flag), 1);
    idle(6);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("sat_max_again", int'(weight), 255);
    check_val("sat_max_noflag", int'(update_w_flag), 0);
    idle(6);

    // Lower saturation from 64 via repeated dt=1 depression.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) pair_ltd(1);
    check_val("sat_min_weight", int'(weight), 0);

    // Coincident spikes, then post at +1.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("coincident_weight", int'(weight), 64);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("after_coincident", int'(weight), 80);
    idle(6);

    // learn_en low blocks pairing; re-enabling mid-window still pairs.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("frozen_weight", int'(weight), 80);
    idle(6);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("reenable_pairs", int'(weight), 88);
    idle(6);

    // Reset between pre and post discards the pairing.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("reset_mid_window", int'(weight), 64);
    idle(6);

    // Random spike trains.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
